// File: rtl/gnn_pkg.sv
// Shared types for the GNN readout path: logit format and the per-node argmax result.
package gnn_pkg;
    localparam int DW    = 21;
    localparam int NODES = 4;

    typedef logic signed [DW-1:0] logit_t;

    typedef struct packed {
        logic          cls;
        logit_t        score;
        logic [DW:0]   margin;
    } node_result_t;
endpackage

// File: rtl/gnn_argmax2.sv
// Two-class argmax for one node: class, winning logit and absolute margin.
// Purely combinational; a tie resolves to class 0 with zero margin.
module gnn_argmax2
    import gnn_pkg::*;
(
    input  logit_t       l0_i,
    input  logit_t       l1_i,
    output node_result_t res_o
);
    logic          gt;
    logic [DW:0]   d10;
    logic [DW:0]   d01;

    // One extra bit so the difference of two extreme logits cannot wrap.
    assign d10 = {l1_i[DW-1], l1_i} - {l0_i[DW-1], l0_i};
    assign d01 = {l0_i[DW-1], l0_i} - {l1_i[DW-1], l1_i};
    assign gt  = l1_i > l0_i;

    always_comb begin
        res_o.cls    = gt;
        res_o.score  = gt ? l1_i : l0_i;
        res_o.margin = gt ? d10 : d01;
    end
endmodule

// File: rtl/gnn_result_collector.sv
// Captures complete logit frames into a small FIFO and streams one argmax beat per node.
// Drops (and counts) frames that arrive while the FIFO is full; flags partial ready patterns.
module gnn_result_collector #(
    parameter int DW     = gnn_pkg::DW,
    parameter int NODES  = gnn_pkg::NODES,
    parameter int FRAMES = 2,
    parameter int CNTW   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NODES*2*DW-1:0] res_in,
    input  logic [NODES*2-1:0]    res_rdy_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            m_node,
    output logic                  m_class,
    output logic [DW-1:0]         m_score,
    output logic [DW:0]           m_margin,
    output logic                  m_last,
    output logic [CNTW-1:0]       drop_cnt,
    output logic                  err_partial
);
    import gnn_pkg::node_result_t;

    localparam int AW = $clog2(FRAMES);
    localparam int NW = $clog2(NODES);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [AW:0]      wr_q, rd_q, cnt;
    logic [AW-1:0]    rd_nx;
    logic [NW-1:0]    beat_q, beat_d, beat_nx;
    node_result_t     out_q, out_d;
    logic [CNTW-1:0]  drop_q;
    logic             err_q;
    logic             all_rdy, any_rdy, hs, last_hs, full, push;

    node_result_t     mem_q   [FRAMES][NODES];
    node_result_t     cap_res [NODES];

    for (genvar n = 0; n < NODES; n++) begin : g_am
        gnn_argmax2 u_am (
            .l0_i  (res_in[(2*n)*DW +: DW]),
            .l1_i  (res_in[(2*n+1)*DW +: DW]),
            .res_o (cap_res[n])
        );
    end

    assign all_rdy = &res_rdy_in;
    assign any_rdy = |res_rdy_in;
    assign cnt     = wr_q - rd_q;
    assign full    = cnt == (AW+1)'(FRAMES);
    assign hs      = (state_q == SEND) && m_ready;
    assign last_hs = hs && (beat_q == NW'(NODES-1));
    // A full FIFO still accepts when its head frame leaves on the same edge.
    assign push    = all_rdy && (!full || last_hs);
    assign rd_nx   = rd_q[AW-1:0] + AW'(1);
    assign beat_nx = beat_q + NW'(1);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (cnt != '0) begin
                    state_d = SEND;
                    beat_d  = '0;
                    out_d   = mem_q[rd_q[AW-1:0]][0];
                end
            end
            SEND: begin
                if (last_hs) begin
                    beat_d = '0;
                    if (cnt > (AW+1)'(1)) begin
                        out_d = mem_q[rd_nx][0];
                    end else if (push) begin
                        // Frame being written this edge becomes the new head; bypass memory.
                        out_d = cap_res[0];
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hs) begin
                    beat_d = beat_nx;
                    out_d  = mem_q[rd_q[AW-1:0]][beat_nx];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            beat_q  <= '0;
            out_q   <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            out_q   <= out_d;
            if (push)    wr_q <= wr_q + (AW+1)'(1);
            if (last_hs) rd_q <= rd_q + (AW+1)'(1);
            if (all_rdy && !push && drop_q != '1) drop_q <= drop_q + CNTW'(1);
            if (any_rdy && !all_rdy) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            for (int n = 0; n < NODES; n++) begin
                mem_q[wr_q[AW-1:0]][n] <= cap_res[n];
            end
        end
    end

    assign m_valid     = state_q == SEND;
    assign m_node      = 2'(beat_q);
    assign m_class     = out_q.cls;
    assign m_score     = out_q.score;
    assign m_margin    = out_q.margin;
    assign m_last      = (state_q == SEND) && (beat_q == NW'(NODES-1));
    assign drop_cnt    = drop_q;
    assign err_partial = err_q;
endmodule

// File: tb/tb_gnn_result_collector.sv
// Directed and random stimulus for gnn_result_collector against a frame-queue reference model.
module tb_gnn_result_collector;
    localparam int DW = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic [167:0]  res_in;
    logic [7:0]    res_rdy_in;
    logic          m_valid, m_ready, m_class, m_last, err_partial;
    logic [1:0]    m_node;
    logic [20:0]   m_score;
    logic [21:0]   m_margin;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    gnn_result_collector dut (
        .clk(clk), .rst(rst), .res_in(res_in), .res_rdy_in(res_rdy_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_node(m_node), .m_class(m_class),
        .m_score(m_score), .m_margin(m_margin), .m_last(m_last),
        .drop_cnt(drop_cnt), .err_partial(err_partial)
    );

    typedef struct { int cls; int score; int margin; } exp_t;

    int   nchk = 0;
    int   nerr = 0;
    exp_t eq[$];      // four entries per stored frame, head frame first
    int   mptr;
    bit   mv;
    int   mdrop;
    bit   merr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t amax(input int l0, input int l1);
        exp_t e;
        if (l1 > l0) e = '{1, l1, l1 - l0};
        else         e = '{0, l0, l0 - l1};
        return e;
    endfunction

    function automatic int logit(input int k);
        logic signed [20:0] v;
        v = res_in[k*DW +: DW];
        return int'(v);
    endfunction

    task automatic setl(input int n, input int a, input int b);
        logic [31:0] ta, tb;
        ta = a;
        tb = b;
        res_in[(2*n)*DW +: DW]   = ta[20:0];
        res_in[(2*n+1)*DW +: DW] = tb[20:0];
    endtask

    task automatic rnd_logits();
        logic [31:0] v;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 6)) - 3;
            else                           v = $urandom;
            res_in[k*DW +: DW] = v[20:0];
        end
    endtask

    // Advance one clock: update the model from pre-edge inputs, then compare after the edge.
    task automatic step();
        int old_f;
        bit hs, lhs;
        exp_t e;
        old_f = eq.size() / 4;
        hs    = mv && m_ready;
        lhs   = hs && (mptr == 3);
        if (rst) begin
            eq.delete();
            mptr = 0; mv = 0; mdrop = 0; merr = 0;
        end else begin
            if (&res_rdy_in) begin
                if (old_f < 2 || lhs) begin
                    for (int n = 0; n < 4; n++) eq.push_back(amax(logit(2*n), logit(2*n+1)));
                end else if (mdrop < 255) begin
                    mdrop++;
                end
            end else if (|res_rdy_in) begin
                merr = 1;
            end
            if (hs) begin
                if (lhs) begin
                    repeat (4) void'(eq.pop_front());
                    mptr = 0;
                end else begin
                    mptr++;
                end
            end
            mv = mv ? (eq.size() > 0) : (old_f > 0);
        end
        @(posedge clk);
        #1;
        chk("m_valid", m_valid, mv);
        chk("drop_cnt", drop_cnt, mdrop);
        chk("err_partial", err_partial, merr);
        if (mv) begin
            e = eq[mptr];
            chk("m_node", m_node, mptr);
            chk("m_class", m_class, e.cls);
            chk("m_score", m_score, e.score & 32'h1FFFFF);
            chk("m_margin", m_margin, e.margin);
            chk("m_last", m_last, mptr == 3);
        end else if (rst) begin
            chk("rst_node", m_node, 0);
            chk("rst_class", m_class, 0);
            chk("rst_score", m_score, 0);
            chk("rst_margin", m_margin, 0);
            chk("rst_last", m_last, 0);
        end
    endtask

    initial begin
        int bc[4], bs[4], bm[4];
        int nv;
        bc = '{0, 1, 0, 0};
        bs = '{5, 9, 7, 0};
        bm = '{8, 11, 0, 1};
        rst = 1'b1; m_ready = 1'b0; res_rdy_in = '0; res_in = '0;
        mptr = 0; mv = 0; mdrop = 0; merr = 0;
        step(); step();
        rst = 1'b0;
        step();

        // Basic frame
        setl(0, 5, -3); setl(1, -2, 9); setl(2, 7, 7); setl(3, 0, -1);
        m_ready = 1'b1; res_rdy_in = 8'hFF;
        step();
        res_rdy_in = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("basic_node%0d", i), m_node, i);
            chk($sformatf("basic_class%0d", i), m_class, bc[i]);
            chk($sformatf("basic_score%0d", i), m_score, bs[i]);
            chk($sformatf("basic_margin%0d", i), m_margin, bm[i]);
            chk($sformatf("basic_last%0d", i), m_last, i == 3);
        end
        step();
        chk("basic_idle", m_valid, 0);

        // Extreme logits
        rnd_logits();
        setl(0, -1048576, 1048575);
        res_rdy_in = 8'hFF;
        step();
        res_rdy_in = '0;
        step();
        chk("ext_class", m_class, 1);
        chk("ext_score", m_score, 1048575);
        chk("ext_margin", m_margin, 2097151);
        repeat (4) step();

        // Backpressure: three frames, two fit
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rnd_logits(); res_rdy_in = 8'hFF; step();
        end
        res_rdy_in = '0;
        step();
        chk("bp_drop", drop_cnt, 1);
        m_ready = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_valid) nv++;
            step();
        end
        chk("bp_beats", nv, 8);

        // Full FIFO with a new frame on the last-beat handshake
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rnd_logits(); res_rdy_in = 8'hFF; step();
        end
        res_rdy_in = '0;
        step();
        m_ready = 1'b1;
        for (int i = 0; i < 10 && !(mv && mptr == 3); i++) step();
        rnd_logits(); res_rdy_in = 8'hFF;
        step();
        res_rdy_in = '0;
        chk("full_pop_drop", drop_cnt, 1);
        repeat (10) step();

        // Partial ready pattern
        rst = 1'b1; step(); rst = 1'b0;
        res_rdy_in = 8'h0F;
        step();
        res_rdy_in = '0;
        chk("partial_err", err_partial, 1);
        chk("partial_valid", m_valid, 0);
        chk("partial_drop", drop_cnt, 0);
        step();

        // Reset in the middle of a frame
        rst = 1'b1; step(); rst = 1'b0;
        rnd_logits(); res_rdy_in = 8'hFF; step(); res_rdy_in = '0;
        m_ready = 1'b1;
        for (int i = 0; i < 10 && !(mv && mptr == 2); i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_valid", m_valid, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_err", err_partial, 0);
        rnd_logits(); res_rdy_in = 8'hFF; step(); res_rdy_in = '0;
        step();
        chk("rst_restart_valid", m_valid, 1);
        chk("rst_restart_node", m_node, 0);
        repeat (5) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            rst = (r < 2);
            r = $urandom_range(0, 99);
            if (r < 25)      res_rdy_in = 8'hFF;
            else if (r < 29) res_rdy_in = 8'($urandom_range(1, 254));
            else             res_rdy_in = '0;
            m_ready = ($urandom_range(0, 2) != 0);
            rnd_logits();
            step();
        end
        rst = 1'b0; res_rdy_in = '0; m_ready = 1'b1;
        repeat (12) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/gnn_result_collector.md
Name: gnn_result_collector

Overview:
- Downstream of the two-layer GNN datapath; consumes its eight 21-bit signed logits (4 nodes x 2 classes) and their per-output ready flags.
- Buffers complete frames in a small frame FIFO and computes argmax class, winning score and margin per node.
- Streams one beat per node over a valid/ready interface to the host/readout logic; counts dropped frames and flags incomplete ready patterns.

Parameters:
- DW, 21, logit width (signed); must match the datapath output width.
- NODES, 4, graph nodes per frame.
- FRAMES, 2, frame FIFO depth; power of two, >= 2.
- CNTW, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- res_in  in  NODES*2*DW  packed logits; slice index k = 2*node + class, bits [k*DW +: DW].
- res_rdy_in  in  NODES*2  per-logit ready flags, same indexing as res_in.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_node  out  2  node index of the beat.
- m_class  out  1  argmax class (0/1).
- m_score  out  DW  winning logit (signed).
- m_margin  out  DW+1  |logit1 - logit0| (unsigned).
- m_last  out  1  high on the node NODES-1 beat.
- drop_cnt  out  CNTW  frames dropped because the FIFO was full; saturating.
- err_partial  out  1  sticky: some but not all res_rdy_in bits high in one cycle.

Behaviour:
- Reset (clk edge with rst=1): FIFO emptied, beat pointer=0, m_valid=0, m_node=0, m_class=0, m_score=0, m_margin=0, m_last=0, drop_cnt=0, err_partial=0. rst overrides all other activity, including an in-flight frame (the frame is discarded, not completed).
- Frame detect: a cycle with &res_rdy_in=1 is one frame. Every such cycle is a separate frame (continuous ready yields one frame per cycle).
- Partial: a cycle with res_rdy_in neither all-0 nor all-1 sets err_partial (cleared only by rst). No capture occurs.
- Capture: the frame is written at that edge if the FIFO is not full, or if it is full and the final beat (m_last) of the head frame handshakes in the same cycle. Otherwise drop_cnt increments, saturating at 2^CNTW-1.
- Argmax is computed at capture and stored per node with the frame. class=1 iff logit1 > logit0 (signed); a tie gives class 0. score = winning logit. margin = logit1-logit0 or logit0-logit1, computed at DW+1 bits with no overflow.
- Output FSM:
  - IDLE: FIFO empty, m_valid=0. Moves to SEND on the edge after a capture into an empty FIFO, so the first beat is valid 1 cycle after the capture edge.
  - SEND: m_* present head frame node = beat pointer. The pointer advances on m_valid&m_ready. On the node NODES-1 handshake, pop the frame and reset the pointer to 0; stay in SEND if the FIFO still holds a frame (next beat valid the following cycle, no bubble), else go to IDLE.
- m_* are registered and held stable while m_valid=1 and m_ready=0.
- Full FIFO and continuous m_ready=1 sustain 1 beat/cycle.

Decomposition:
- Shared package gnn_pkg: DW, NODES, a logit_t signed typedef, and a node_result_t struct {class, score, margin}.
- One sub-module, gnn_argmax2: purely combinational, two logit_t in, node_result_t out. The collector instantiates it NODES times. FIFO and FSM stay in the top.

Test Plan:
- Basic: node0 (5,-3), node1 (-2,9), node2 (7,7), node3 (0,-1), all ready for 1 cycle, m_ready=1 -> 4 consecutive beats starting 1 cycle after capture: (0,0,5,8), (1,1,9,11), (2,0,7,0), (3,0,0,1); m_last only on beat 4.
- Extremes: node0 (-1048576, 1048575) -> class 1, score 1048575, margin 2097151, no wrap.
- Backpressure: m_ready=0, 3 single-cycle frames -> 2 stored, drop_cnt=1. Release m_ready -> 8 beats in order with no bubble between frames.
- Full plus simultaneous pop: FIFO full, frame arrives on the same cycle as the m_last handshake -> frame accepted, drop_cnt unchanged.
- Partial: res_rdy_in=8'h0F for 1 cycle -> err_partial=1, no m_valid, drop_cnt=0.
- Reset: assert rst after beat 2 of a frame -> next cycle m_valid=0, drop_cnt=0, err_partial=0; a new frame then streams from node 0.
